// File: rtl/trace_commit_scheduler_pkg.sv
// trace_commit_scheduler_pkg: slot state, tag type and trace record pack/unpack shared by the commit scheduler and trackers
package trace_commit_scheduler_pkg;
  localparam int TRACE_W = 256;
  localparam int DEFAULT_DEPTH = 4;
  localparam int TAG_W = $clog2(DEFAULT_DEPTH);
  typedef logic [TAG_W-1:0] tag_t;
  typedef struct packed {
    logic alloc;
    logic done;
  } commit_slot_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
    logic [63:0] mem_addr;
    logic [25:0] rsvd;
  } trace_output;
  function automatic logic [TRACE_W-1:0] pack_trace(input trace_output t);
    return t;
  endfunction
  function automatic trace_output unpack_trace(input logic [TRACE_W-1:0] v);
    return v;
  endfunction
endpackage

// File: rtl/trace_commit_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at a rotating pointer that advances past the winner on accept
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] r_ptr;
  logic          w_found;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++)
      if (!w_found && i_req[(int'(r_ptr) + k) % N]) begin
        w_found = 1'b1;
        o_idx = IW'((int'(r_ptr) + k) % N);
      end
    if (w_found) o_gnt[o_idx] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_adv) r_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/trace_commit_scheduler.sv
// trace_commit_scheduler: in-order reorder buffer collecting out-of-order trace records from several trackers
module trace_commit_scheduler
  import trace_commit_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int TRACE_WIDTH = 256,
  parameter int DEPTH = 4,
  localparam int TAG_WIDTH = $clog2(DEPTH),
  localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           alloc_req,
  output logic                           alloc_gnt,
  output logic [TAG_WIDTH-1:0]           alloc_tag,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]   src_tag,
  input  logic [NUM_SRC*TRACE_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic                           out_valid,
  output logic [TRACE_WIDTH-1:0]         out_data,
  input  logic                           out_ready,
  output logic [TAG_WIDTH:0]             occupancy,
  output logic                           err_o
);
  commit_slot_t            r_slot [DEPTH];
  logic [TRACE_WIDTH-1:0]  r_data [DEPTH];
  logic [TAG_WIDTH-1:0]    r_head, r_tail;
  logic [TAG_WIDTH:0]      r_count;
  logic                    r_err;
  logic [NUM_SRC-1:0]      w_gnt;
  logic [IW-1:0]           w_idx;
  logic [TAG_WIDTH-1:0]    w_tag;
  logic [TRACE_WIDTH-1:0]  w_data;
  logic                    w_xfer, w_legal, w_retire;
  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush),
    .i_req (src_valid),
    .i_adv (w_xfer),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );
  assign src_ready = flush ? '0 : w_gnt;
  assign w_xfer    = |src_ready;
  assign w_tag     = src_tag[w_idx*TAG_WIDTH +: TAG_WIDTH];
  assign w_data    = src_data[w_idx*TRACE_WIDTH +: TRACE_WIDTH];
  assign w_legal   = r_slot[w_tag].alloc & ~r_slot[w_tag].done;
  // full blocks allocation even when the head retires this cycle
  assign alloc_gnt = alloc_req & ~flush & (r_count < (TAG_WIDTH+1)'(DEPTH));
  assign alloc_tag = r_tail;
  assign out_valid = ~flush & r_slot[r_head].alloc & r_slot[r_head].done;
  assign out_data  = r_data[r_head];
  assign w_retire  = out_valid & out_ready;
  assign occupancy = r_count;
  assign err_o     = r_err;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= '0;
        r_data[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_xfer && w_legal) begin
        r_slot[w_tag].done <= 1'b1;
        r_data[w_tag] <= w_data;
      end
      r_err <= r_err | (w_xfer & ~w_legal);
      if (w_retire) begin
        r_slot[r_head] <= '0;
        r_head <= r_head + 1'b1;
      end
      if (alloc_gnt) begin
        r_slot[r_tail] <= '{alloc: 1'b1, done: 1'b0};
        r_tail <= r_tail + 1'b1;
      end
      r_count <= r_count + (TAG_WIDTH+1)'(alloc_gnt) - (TAG_WIDTH+1)'(w_retire);
    end
endmodule

// File: tb/tb_trace_commit_scheduler.sv
// tb_trace_commit_scheduler: directed and random stimulus checked against a slot-level reference model
module tb_trace_commit_scheduler;
  localparam int NS = 2;
  localparam int TW = 256;
  localparam int D = 4;
  localparam int TAGW = 2;
  logic clk = 1'b0;
  logic rst, flush, alloc_req, alloc_gnt, out_valid, out_ready, err_o;
  logic [TAGW-1:0]    alloc_tag;
  logic [NS-1:0]      src_valid, src_ready;
  logic [NS*TAGW-1:0] src_tag;
  logic [NS*TW-1:0]   src_data;
  logic [TW-1:0]      out_data;
  logic [TAGW:0]      occupancy;
  trace_commit_scheduler #(.NUM_SRC(NS), .TRACE_WIDTH(TW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_tag(alloc_tag), .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
    .src_ready(src_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .err_o(err_o)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  bit m_alloc [D];
  bit m_done [D];
  logic [TW-1:0] m_data [D];
  int m_head, m_tail, m_count, m_rr;
  bit m_err;
  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [TW-1:0] rnd();
    logic [TW-1:0] r;
    for (int k = 0; k < TW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic m_clear(input bit hard);
    for (int i = 0; i < D; i++) begin
      m_alloc[i] = 0;
      m_done[i] = 0;
      if (hard) m_data[i] = '0;
    end
    m_head = 0;
    m_tail = 0;
    m_count = 0;
    m_rr = 0;
    if (hard) m_err = 0;
  endtask
  task automatic idle();
    flush = 0;
    alloc_req = 0;
    src_valid = '0;
    src_tag = '0;
    src_data = '0;
    out_ready = 0;
  endtask
  task automatic src(input int i, input int tag);
    src_valid[i] = 1'b1;
    src_tag[i*TAGW +: TAGW] = TAGW'(tag);
    src_data[i*TW +: TW] = rnd();
  endtask
  // called just after a rising edge with inputs already driven
  task automatic step();
    int w, t;
    bit e_gnt, e_ov;
    #3;
    e_gnt = alloc_req && m_count < D && !flush;
    e_ov = !flush && m_alloc[m_head] && m_done[m_head];
    w = -1;
    if (!flush)
      for (int k = 0; k < NS; k++)
        if (w < 0 && src_valid[(m_rr + k) % NS]) w = (m_rr + k) % NS;
    chk("alloc_gnt", alloc_gnt, e_gnt);
    chk("alloc_tag", alloc_tag, m_tail);
    chk("src_ready", src_ready, w < 0 ? 0 : (1 << w));
    chk("out_valid", out_valid, e_ov);
    chk("out_data", out_data, m_data[m_head]);
    chk("occupancy", occupancy, m_count);
    chk("err_o", err_o, m_err);
    @(posedge clk);
    if (flush) m_clear(0);
    else begin
      if (w >= 0) begin
        t = int'(src_tag[w*TAGW +: TAGW]);
        if (m_alloc[t] && !m_done[t]) begin
          m_done[t] = 1;
          m_data[t] = src_data[w*TW +: TW];
        end else m_err = 1;
        m_rr = (w + 1) % NS;
      end
      if (e_ov && out_ready) begin
        m_alloc[m_head] = 0;
        m_done[m_head] = 0;
        m_head = (m_head + 1) % D;
        m_count--;
      end
      if (e_gnt) begin
        m_alloc[m_tail] = 1;
        m_done[m_tail] = 0;
        m_tail = (m_tail + 1) % D;
        m_count++;
      end
    end
    #1;
  endtask
  task automatic do_flush();
    idle();
    flush = 1;
    step();
    idle();
  endtask
  task automatic allocn(input int n);
    idle();
    alloc_req = 1;
    repeat (n) step();
    idle();
  endtask
  task automatic drain(input int n);
    idle();
    out_ready = 1;
    repeat (n) step();
    idle();
  endtask
  initial begin
    int pend[$];
    int k;
    rst = 1;
    idle();
    m_clear(1);
    step();
    rst = 0;
    step();
    // in-order completion
    do_flush();
    allocn(3);
    for (int i = 0; i < 3; i++) begin
      idle(); out_ready = 1; src(0, i); step();
    end
    drain(3);
    // out-of-order completion, head written last
    do_flush();
    allocn(4);
    idle(); out_ready = 1; src(1, 3); step();
    idle(); out_ready = 1; src(1, 1); step();
    idle(); out_ready = 1; src(1, 2); step();
    idle(); out_ready = 1; src(0, 0); step();
    drain(5);
    // both sources requesting: grants alternate
    do_flush();
    allocn(4);
    idle(); src(0, 0); src(1, 1); step();
    idle(); src(0, 2); src(1, 1); step();
    idle(); src(0, 2); src(1, 3); step();
    idle(); src(0, 2); src(1, 3); step();
    drain(5);
    // full: retire cycle still refuses allocation, next cycle wraps to tag 0
    do_flush();
    allocn(4);
    idle(); alloc_req = 1; src(0, 0); step();
    idle(); alloc_req = 1; out_ready = 1; step();
    idle(); alloc_req = 1; step();
    // random legal traffic with occasional flushes
    do_flush();
    repeat (400) begin
      idle();
      pend.delete();
      for (int i = 0; i < D; i++) if (m_alloc[i] && !m_done[i]) pend.push_back(i);
      alloc_req = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 49) == 0;
      if (pend.size() > 0) begin
        k = $urandom_range(0, pend.size() - 1);
        if ($urandom_range(0, 3) != 0) src(0, pend[k]);
        if (pend.size() > 1 && $urandom_range(0, 3) != 0) src(1, pend[(k + 1) % pend.size()]);
      end
      step();
    end
    drain(6);
    // illegal writes: unallocated slot, then an already-done slot
    do_flush();
    allocn(2);
    idle(); src(0, 2); step();
    idle(); src(0, 0); step();
    idle(); src(0, 0); step();
    idle(); step();
    // flush racing allocation and writes keeps err_o
    idle(); flush = 1; alloc_req = 1; src(0, 1); src(1, 0); step();
    idle(); step();
    // async reset with completed records pending
    do_flush();
    allocn(3);
    for (int i = 0; i < 3; i++) begin
      idle(); src(i % NS, i); step();
    end
    idle();
    step();
    rst = 1;
    #1;
    chk("rst_alloc_gnt", alloc_gnt, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_err_o", err_o, 0);
    m_clear(1);
    @(posedge clk);
    #1;
    rst = 0;
    step();
    allocn(1);
    idle(); out_ready = 1; src(1, 0); step();
    drain(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/trace_commit_scheduler.md
Name: trace_commit_scheduler

Overview:
- Shares one reorder buffer between several trace trackers (e.g. EX and WB trackers) that finish trace records out of program order.
- Allocates in-order slot tags when an instruction enters tracing and accepts completed records from NUM_SRC sources through a round-robin arbiter.
- Retires records strictly in allocation order to the single trace sink using a valid/ready handshake.

Parameters:
- NUM_SRC, 2, number of completing tracker sources (>=1).
- TRACE_WIDTH, 256, width of one packed trace record in bits.
- DEPTH, 4, reorder slots; power of two, >=2.
- TAG_WIDTH, $clog2(DEPTH), slot tag width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all slots (pipeline flush).
- alloc_req  in  1  allocate a slot for a new traced instruction.
- alloc_gnt  out  1  allocation accepted this cycle.
- alloc_tag  out  TAG_WIDTH  tag of the granted slot (= tail pointer).
- src_valid  in  NUM_SRC  source i offers a completed record.
- src_tag  in  NUM_SRC*TAG_WIDTH  tag per source (source i at bits [i*TAG_WIDTH +: TAG_WIDTH]).
- src_data  in  NUM_SRC*TRACE_WIDTH  record per source.
- src_ready  out  NUM_SRC  one-hot grant; transfer = src_valid[i] & src_ready[i].
- out_valid  out  1  head record complete.
- out_data  out  TRACE_WIDTH  head record.
- out_ready  in  1  sink accepts.
- occupancy  out  TAG_WIDTH+1  allocated-slot count.
- err_o  out  1  sticky: write to a free or already-done slot.

Behaviour:
- State per slot: alloc bit, done bit, data register. Head/tail pointers TAG_WIDTH bits, wrapping modulo DEPTH. Count is TAG_WIDTH+1 bits.
- Reset (asynchronous) and flush (synchronous) both clear:
  - all alloc/done bits, head, tail, count, rr_ptr.
  - err_o (cleared by reset only; flush leaves it unchanged).
- Outputs after reset: alloc_gnt=0, src_ready=0, out_valid=0, out_data=0 (data regs cleared), occupancy=0, err_o=0.
- Flush has priority over every other event in the same cycle. alloc_gnt, src_ready and out_valid are forced to 0 while flush=1.
- Allocation:
  - alloc_gnt = alloc_req & (count < DEPTH). It does not depend on a same-cycle retire.
  - On grant: slot[tail].alloc=1, done=0, tail++.
  - alloc_tag = tail, combinational.
- Arbitration:
  - Round-robin over src_valid, starting the search at rr_ptr. Exactly one src_ready is high, and only when some src_valid is high.
  - After a transfer, rr_ptr = winner+1 mod NUM_SRC. With no transfer, rr_ptr holds.
  - The grant ignores tag legality; an illegal write is still consumed.
- Write: on a transfer to tag t:
  - If slot t has alloc=1 and done=0: store data, set done=1.
  - Otherwise: drop the write and set err_o=1.
- Retire:
  - out_valid = slot[head].alloc & slot[head].done, from registers only. There is no combinational path from src_* or alloc_* to out_*.
  - out_data = slot[head].data.
  - On out_valid & out_ready: clear alloc/done of head, head++.
- Latency: a record written at edge N is visible on out_valid after edge N (earliest cycle N+1). Back-to-back retires are one per cycle.
- Count update: count += gnt − retire. Simultaneous alloc and retire leaves count unchanged.
- Full: while count==DEPTH, alloc_gnt=0 even if a retire happens the same cycle; the grant comes in the next cycle.
- Empty: out_valid=0 and occupancy=0.
- A write and a retire never target the same slot in one cycle (head must be done to retire). Same-cycle write to a non-head slot plus retire of head are both performed.

Decomposition:
- Shared package ryuki_datatypes gets:
  - a typedef commit_slot_t {alloc, done};
  - a localparam-driven tag typedef;
  - pack/unpack functions between trace_output and the TRACE_WIDTH vector, so trackers connect directly.
- One sub-module, rr_arbiter (NUM_SRC requests -> one-hot grant, rotating pointer, advance-on-accept input), is reused for later multi-tracker sharing.

Test Plan:
- In-order: 3 allocs (tags 0,1,2), src0 completes 0,1,2 in order, out_ready=1 -> out_data in order 0,1,2 on consecutive cycles; first out_valid the cycle after the tag-0 write; occupancy 3->0.
- Out-of-order: allocate 0..3; src1 writes 3, then 1, then 2; src0 writes 0 last -> out_valid stays 0 until tag 0 written, then 0,1,2,3 retire back-to-back.
- Arbitration: src_valid=2'b11 held 4 cycles with distinct legal tags -> src_ready sequence 01,10,01,10; all four records are stored.
- Full/backpressure: allocate 4 (count=4), alloc_req held with out_ready=0 -> alloc_gnt=0. A retire cycle still gives alloc_gnt=0; the next cycle gives alloc_gnt=1 with alloc_tag=0 (wrapped).
- Error: write tag 2 while only tags 0,1 are allocated -> src_ready pulses, err_o=1 from the next cycle, slot 2 unchanged; a second write to a done slot also keeps err_o=1.
- Reset/flush: assert rst mid-operation with 3 slots done -> all outputs 0 immediately. Separately, flush concurrent with alloc_req and src_valid -> no grant, occupancy=0 next cycle, err_o retained.
